cpu_step_controller: RTL and testbench

Multi-cycle phase sequencer for the single-cycle RV32 datapath. It replaces the free-running 3-bit phase counter in the CPU top with an explicit FSM that generates per-phase enables for fetch, register file, data memory and PC. It adds run / single-step / halt control from debounced board buttons, memory wait-state stalling with a timeout, and cycle and retired-instruction counters for on-board debug display.

---
 rtl/cpu_step_controller.sv | 106 ++++++++++
 tb/tb_cpu_step_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_controller.sv
// Phase sequencer for the RV32 datapath: IF/ID/EX/MEM/WB enables, run/step/halt
// control, MEM wait-state timeout, and cycle / retired-instruction counters.
module cpu_step_controller #(
  parameter int unsigned AUTORUN    = 1,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_pulse,
  input  logic             step_pulse,
  input  logic             halt_pulse,
  input  logic             halt_req,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic [2:0]       phase,
  output logic             if_en,
  output logic             rf_rd_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             running,
  output logic             fault,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5
  } state_t;

  localparam state_t     RESET_STATE = (AUTORUN != 0) ? S_IF : S_IDLE;
  localparam logic [7:0] WAIT_MAX    = 8'(WAIT_LIMIT);

  state_t     state;
  logic       step_mode;
  logic       halt_pending;
  logic [7:0] wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RESET_STATE;
      step_mode    <= 1'b0;
      halt_pending <= 1'b0;
      fault        <= 1'b0;
      cycle_count  <= '0;
      instret      <= '0;
      wait_cnt     <= '0;
    end else begin
      if (state != S_IDLE) begin
        cycle_count <= cycle_count + CNT_W'(1);
        if (halt_pulse)
          halt_pending <= 1'b1;
      end
      // Every transition into IDLE below also clears halt_pending, overriding the set above.
      unique case (state)
        S_IDLE: begin
          if (step_pulse || run_pulse) begin
            state     <= S_IF;
            step_mode <= step_pulse;
            fault     <= 1'b0;
          end
        end
        S_IF: state <= S_ID;
        S_ID: state <= S_EX;
        S_EX: begin
          state    <= S_MEM;
          wait_cnt <= '0;
        end
        S_MEM: begin
          if (!mem_req || mem_ready) begin
            state <= S_WB;
          end else if (wait_cnt == WAIT_MAX) begin
            state        <= S_IDLE;
            fault        <= 1'b1;
            halt_pending <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_WB: begin
          instret <= instret + CNT_W'(1);
          if (halt_req || step_mode || halt_pending || halt_pulse) begin
            state        <= S_IDLE;
            halt_pending <= 1'b0;
          end else begin
            state <= S_IF;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign phase    = state;
  assign if_en    = (state == S_IF);
  assign rf_rd_en = (state == S_ID);
  assign mem_en   = (state == S_MEM) && mem_req;
  assign wb_en    = (state == S_WB);
  assign running  = (state != S_IDLE);

endmodule

// File: tb/tb_cpu_step_controller.sv
// Bench for cpu_step_controller: two instances (autorun / halted-at-reset) sharing
// stimulus, checked every cycle against an instruction-level reference model.
module tb_cpu_step_controller;

  logic clk = 1'b0;
  logic rst, run_p, step_p, halt_p, halt_rq, mreq, mrdy;

  logic [2:0]  ph [2];
  logic        ife [2], rfe [2], mee [2], wbe [2], run [2], flt [2];
  logic [31:0] cc0, ir0;
  logic [5:0]  cc1, ir1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_step_controller #(.AUTORUN(1), .CNT_W(32), .WAIT_LIMIT(15)) u_a (
    .clk(clk), .rst(rst), .run_pulse(run_p), .step_pulse(step_p), .halt_pulse(halt_p),
    .halt_req(halt_rq), .mem_req(mreq), .mem_ready(mrdy),
    .phase(ph[0]), .if_en(ife[0]), .rf_rd_en(rfe[0]), .mem_en(mee[0]), .wb_en(wbe[0]),
    .running(run[0]), .fault(flt[0]), .cycle_count(cc0), .instret(ir0));

  cpu_step_controller #(.AUTORUN(0), .CNT_W(6), .WAIT_LIMIT(3)) u_b (
    .clk(clk), .rst(rst), .run_pulse(run_p), .step_pulse(step_p), .halt_pulse(halt_p),
    .halt_req(halt_rq), .mem_req(mreq), .mem_ready(mrdy),
    .phase(ph[1]), .if_en(ife[1]), .rf_rd_en(rfe[1]), .mem_en(mee[1]), .wb_en(wbe[1]),
    .running(run[1]), .fault(flt[1]), .cycle_count(cc1), .instret(ir1));

  // Reference model: tracks an instruction by its age (cycles since IF), MEM stall
  // count and a retire flag, not by the controller's state encoding.
  localparam int          AR [2] = '{1, 0};
  localparam int          WL [2] = '{15, 3};
  localparam longint unsigned MASK [2] = '{64'hFFFF_FFFF, 64'h3F};

  bit m_act [2], m_wb [2], m_step [2], m_hp [2], m_flt [2];
  int m_age [2], m_stall [2];
  longint unsigned m_cyc [2], m_ins [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = (AR[i] != 0); m_wb[i] = 0; m_step[i] = 0; m_hp[i] = 0; m_flt[i] = 0;
      m_age[i] = 0; m_stall[i] = 0; m_cyc[i] = 0; m_ins[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    if (!m_act[i]) begin
      if (run_p || step_p) begin
        m_act[i] = 1; m_age[i] = 0; m_wb[i] = 0; m_step[i] = step_p; m_flt[i] = 0;
      end
    end else begin
      m_cyc[i] = (m_cyc[i] + 1) & MASK[i];
      if (halt_p) m_hp[i] = 1;
      if (m_wb[i]) begin
        m_ins[i] = (m_ins[i] + 1) & MASK[i];
        if (halt_rq || m_step[i] || m_hp[i]) m_act[i] = 0;
        else begin m_age[i] = 0; m_wb[i] = 0; end
      end else if (m_age[i] < 3) begin
        m_age[i]++;
        m_stall[i] = 0;
      end else if (!mreq || mrdy) begin
        m_wb[i] = 1;
      end else if (m_stall[i] == WL[i]) begin
        m_act[i] = 0; m_flt[i] = 1;
      end else begin
        m_stall[i]++;
      end
      if (!m_act[i]) m_hp[i] = 0;
    end
  endtask

  function automatic int exp_phase(input int i);
    if (!m_act[i]) return 0;
    if (m_wb[i]) return 5;
    if (m_age[i] < 3) return m_age[i] + 1;
    return 4;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_inst(input int i, input logic [63:0] cc, input logic [63:0] ir);
    int ep;
    ep = exp_phase(i);
    chk($sformatf("u%0d.phase", i), 64'(ph[i]), 64'(ep));
    chk($sformatf("u%0d.if_en", i), 64'(ife[i]), 64'(ep == 1));
    chk($sformatf("u%0d.rf_rd_en", i), 64'(rfe[i]), 64'(ep == 2));
    chk($sformatf("u%0d.mem_en", i), 64'(mee[i]), 64'((ep == 4) && mreq));
    chk($sformatf("u%0d.wb_en", i), 64'(wbe[i]), 64'(ep == 5));
    chk($sformatf("u%0d.running", i), 64'(run[i]), 64'(ep != 0));
    chk($sformatf("u%0d.fault", i), 64'(flt[i]), 64'(m_flt[i]));
    chk($sformatf("u%0d.cycle_count", i), cc, m_cyc[i]);
    chk($sformatf("u%0d.instret", i), ir, m_ins[i]);
  endtask

  task automatic compare_all();
    check_inst(0, 64'(cc0), 64'(ir0));
    check_inst(1, 64'(cc1), 64'(ir1));
  endtask

  task automatic tick();
    if (rst) model_reset();
    else begin model_step(0); model_step(1); end
    @(posedge clk); #1;
    compare_all();
  endtask

  typedef struct {
    logic r, s, h;
    int   pa, pb, ia, ib;
  } vec_t;
  vec_t tbl [12];

  initial begin
    int memc, wbs;
    bit done;

    tbl[0]  = '{0, 1, 0, 2, 1, 10, 0};
    tbl[1]  = '{1, 0, 0, 3, 2, 10, 0};
    tbl[2]  = '{0, 0, 1, 4, 3, 10, 0};
    tbl[3]  = '{0, 0, 0, 5, 4, 10, 0};
    tbl[4]  = '{0, 0, 0, 0, 5, 11, 0};
    tbl[5]  = '{0, 0, 1, 0, 0, 11, 1};
    tbl[6]  = '{1, 1, 0, 1, 1, 11, 1};
    tbl[7]  = '{0, 0, 0, 2, 2, 11, 1};
    tbl[8]  = '{0, 0, 0, 3, 3, 11, 1};
    tbl[9]  = '{0, 0, 0, 4, 4, 11, 1};
    tbl[10] = '{0, 0, 0, 5, 5, 11, 1};
    tbl[11] = '{0, 0, 0, 0, 0, 12, 2};

    rst = 1; run_p = 0; step_p = 0; halt_p = 0; halt_rq = 0; mreq = 0; mrdy = 0;
    #3;
    model_reset();
    compare_all();
    chk("reset_phase_a", 64'(ph[0]), 64'd1);
    chk("reset_phase_b", 64'(ph[1]), 64'd0);
    @(negedge clk); rst = 0;

    // Free-running from reset: retire every 5 cycles.
    for (int c = 1; c <= 50; c++) begin
      tick();
      chk("wb_cadence", 64'(wbe[0]), 64'(((c + 1) % 5) == 0));
    end
    chk("run50_instret", 64'(ir0), 64'd10);
    chk("run50_cycles", 64'(cc0), 64'd50);

    // Step / halt / ignored-pulse sequence.
    for (int k = 0; k < 12; k++) begin
      run_p = tbl[k].r; step_p = tbl[k].s; halt_p = tbl[k].h;
      tick();
      chk($sformatf("tbl%0d.phase_a", k), 64'(ph[0]), 64'(tbl[k].pa));
      chk($sformatf("tbl%0d.phase_b", k), 64'(ph[1]), 64'(tbl[k].pb));
      chk($sformatf("tbl%0d.instret_a", k), 64'(ir0), 64'(tbl[k].ia));
      chk($sformatf("tbl%0d.instret_b", k), 64'(ir1), 64'(tbl[k].ib));
    end
    run_p = 0; step_p = 0; halt_p = 0;
    chk("step_cycles_b", 64'(cc1), 64'd10);

    // Three MEM wait states, then ready; halt_req stops at WB.
    run_p = 1; tick(); run_p = 0;
    tick(); tick(); tick();
    wbs = 0;
    mreq = 1; mrdy = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_mem", 64'(ph[0]), 64'd4);
    end
    mrdy = 1; tick();
    chk("stall_wb", 64'(ph[0]), 64'd5);
    if (wbe[0]) wbs++;
    mreq = 0; mrdy = 0; halt_rq = 1; tick(); halt_rq = 0;
    if (wbe[0]) wbs++;
    chk("stall_idle", 64'(ph[0]), 64'd0);
    chk("stall_wb_count", 64'(wbs), 64'd1);
    chk("stall_cycles", 64'(cc0), 64'd68);
    chk("stall_instret", 64'(ir0), 64'd13);

    // Memory timeout with mem_ready stuck low.
    run_p = 1; tick(); run_p = 0;
    mreq = 1; mrdy = 0;
    memc = 0; wbs = 0; done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      tick();
      if (ph[0] == 3'd4) memc++;
      if (wbe[0]) wbs++;
      if (ph[0] == 3'd0) done = 1;
    end
    chk("timeout_reached", 64'(done), 64'd1);
    chk("timeout_mem_cycles", 64'(memc), 64'd16);
    chk("timeout_fault", 64'(flt[0]), 64'd1);
    chk("timeout_no_wb", 64'(wbs), 64'd0);
    chk("timeout_instret", 64'(ir0), 64'd13);
    mreq = 0;
    run_p = 1; tick(); run_p = 0;
    chk("fault_cleared", 64'(flt[0]), 64'd0);

    // Asynchronous reset in the middle of MEM.
    tick(); tick(); tick();
    chk("pre_rst_mem", 64'(ph[0]), 64'd4);
    #2 rst = 1;
    #1 model_reset();
    compare_all();
    chk("async_rst_phase", 64'(ph[0]), 64'd1);
    chk("async_rst_cycles", 64'(cc0), 64'd0);
    @(negedge clk); rst = 0;

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      run_p   = ($urandom_range(15) == 0);
      step_p  = ($urandom_range(15) == 0);
      halt_p  = ($urandom_range(23) == 0);
      halt_rq = ($urandom_range(7) == 0);
      mreq    = $urandom_range(1);
      mrdy    = ($urandom_range(2) == 0);
      rst     = ($urandom_range(499) == 0);
      tick();
    end
    rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
